lif_neuron_core: RTL

Leaky integrate-and-fire neuron that consumes the 16 presynaptic spike lines and the STDP-updated 4-bit synaptic weights. It produces the postsynaptic spike that feeds back into the STDP timing block as its post spike input. It holds a local weight register file, written by the STDP stage. Once per time step it serially integrates weighted spikes, applies leak, fires, and enforces a refractory period.

---
 rtl/snn_pkg.sv | 27 ++
 rtl/synapse_weight_rf.sv | 37 +++
 rtl/lif_neuron_core.sv | 128 ++++++++++++
 3 files changed

// File: rtl/snn_pkg.sv
// Shared types and sizes for the spiking-neuron datapath; the STDP block
// reuses weight_t so both sides agree on the weight format.
package snn_pkg;

  localparam int N_SYN   = 16;
  localparam int W_WIDTH = 4;
  localparam int V_WIDTH = 10;
  localparam int IDX_W   = $clog2(N_SYN);

  typedef logic [W_WIDTH-1:0] weight_t;

  typedef enum logic [1:0] {
    IDLE,
    LEAK,
    ACCUM,
    FIRE
  } neuron_state_t;

  // Membrane + weight, clamped at the top of the V_WIDTH range.
  function automatic logic [V_WIDTH-1:0] sat_add(input logic [V_WIDTH-1:0] a,
                                                 input weight_t            b);
    logic [V_WIDTH:0] s;
    s = {1'b0, a} + (V_WIDTH + 1)'(b);
    return s[V_WIDTH] ? {V_WIDTH{1'b1}} : s[V_WIDTH-1:0];
  endfunction

endpackage

// File: rtl/synapse_weight_rf.sv
// Synaptic weight register file: one write port from STDP, two combinational
// read ports (accumulation index and external debug/STDP index).
module synapse_weight_rf
  import snn_pkg::*;
#(
  parameter int INIT_WEIGHT = 8
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_sel,
  input  weight_t          wr_weight,
  input  logic [IDX_W-1:0] acc_sel,
  output weight_t          acc_weight,
  input  logic [IDX_W-1:0] rd_sel,
  output weight_t          rd_weight
);

  weight_t w_q [N_SYN];

  generate
    for (genvar gi = 0; gi < N_SYN; gi++) begin : g_weight
      always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
          w_q[gi] <= W_WIDTH'(INIT_WEIGHT);
        end else if (wr_en && (wr_sel == IDX_W'(gi))) begin
          w_q[gi] <= wr_weight;
        end
      end
    end
  endgenerate

  // Reads see the pre-edge value, so a same-cycle write never disturbs accumulation.
  assign acc_weight = w_q[acc_sel];
  assign rd_weight  = w_q[rd_sel];

endmodule

// File: rtl/lif_neuron_core.sv
// Leaky integrate-and-fire neuron: per time step it leaks, serially integrates
// the latched weighted spikes, fires against a threshold and tracks refractoriness.
module lif_neuron_core
  import snn_pkg::*;
#(
  parameter int THRESHOLD    = 64,
  parameter int LEAK_SHIFT   = 3,
  parameter int REFRAC_STEPS = 2,
  parameter int INIT_WEIGHT  = 8
) (
  input  logic               clock,
  input  logic               rst_n,
  input  logic               time_step,
  input  logic [N_SYN-1:0]   pre_spike,
  input  logic               wr_en,
  input  logic [IDX_W-1:0]   wr_sel,
  input  weight_t            wr_weight,
  input  logic [IDX_W-1:0]   rd_sel,
  output weight_t            rd_weight,
  output logic               post_spike,
  output logic               step_done,
  output logic               busy,
  output logic [V_WIDTH-1:0] membrane,
  output logic               refractory
);

  localparam int R_W = (REFRAC_STEPS > 0) ? $clog2(REFRAC_STEPS + 1) : 1;

  neuron_state_t      state_q, state_d;
  logic [V_WIDTH-1:0] v_q, v_d;
  logic [N_SYN-1:0]   latch_q, latch_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [R_W-1:0]     refrac_q, refrac_d;
  logic               post_q, post_d;
  logic               done_q, done_d;
  weight_t            acc_weight;

  synapse_weight_rf #(
    .INIT_WEIGHT(INIT_WEIGHT)
  ) u_rf (
    .clock      (clock),
    .rst_n      (rst_n),
    .wr_en      (wr_en),
    .wr_sel     (wr_sel),
    .wr_weight  (wr_weight),
    .acc_sel    (idx_q),
    .acc_weight (acc_weight),
    .rd_sel     (rd_sel),
    .rd_weight  (rd_weight)
  );

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      v_q      <= '0;
      latch_q  <= '0;
      idx_q    <= '0;
      refrac_q <= '0;
      post_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      v_q      <= v_d;
      latch_q  <= latch_d;
      idx_q    <= idx_d;
      refrac_q <= refrac_d;
      post_q   <= post_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    v_d      = v_q;
    latch_d  = latch_q;
    idx_d    = idx_q;
    refrac_d = refrac_q;
    post_d   = 1'b0;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (time_step) begin
          latch_d = pre_spike;
          idx_d   = '0;
          state_d = LEAK;
        end
      end
      LEAK: begin
        // A refractory step skips integration entirely.
        if (refrac_q != '0) begin
          v_d     = '0;
          state_d = FIRE;
        end else begin
          v_d     = v_q - (v_q >> LEAK_SHIFT);
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        if (latch_q[idx_q]) begin
          v_d = sat_add(v_q, acc_weight);
        end
        idx_d = idx_q + IDX_W'(1);
        if (idx_q == IDX_W'(N_SYN - 1)) begin
          state_d = FIRE;
        end
      end
      FIRE: begin
        if ((refrac_q == '0) && (v_q >= V_WIDTH'(THRESHOLD))) begin
          post_d   = 1'b1;
          v_d      = '0;
          refrac_d = R_W'(REFRAC_STEPS);
        end else if (refrac_q != '0) begin
          refrac_d = refrac_q - R_W'(1);
        end
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign post_spike = post_q;
  assign step_done  = done_q;
  assign busy       = (state_q != IDLE);
  assign membrane   = v_q;
  assign refractory = (refrac_q != '0);

endmodule
